// File: rtl/pdp11_instr_encoder.sv
// PDP-11 instruction encoder: turns one symbolic instruction (mnemonic code plus
// addressing fields and extension values) into 1-3 machine words, streamed over
// valid/ready in the order instruction word, source extension, destination extension.
//
// Mnemonic codes (MNEM_W bits):
//   0-9   MOV,MOVB,CMP,CMPB,BIT,BITB,BIC,BICB,BIS,BISB   10 ADD   11 SUB
//   12-26 BR,BNE,BEQ,BGE,BLT,BGT,BLE,BPL,BMI,BHI,BLOS,BVC,BVS,BCC,BCS
//   27 JMP  28 JSR
//   29-52 CLR,CLRB,COM,COMB,INC,INCB,DEC,DECB,NEG,NEGB,ADC,ADCB,SBC,SBCB,
//         TST,TSTB,ROR,RORB,ROL,ROLB,ASR,ASRB,ASL,ASLB
//   53 RTS  54 SWAB  55 HALT  56 NOP  57-64 CLC,CLV,CLZ,CLN,SEC,SEV,SEZ,SEN
//
// Optional build macro PDP11_ENC_TRACE_EN: logs every emitted word and every
// rejected request to the simulation transcript; ports and timing unchanged.
module pdp11_instr_encoder #(
  parameter int MNEM_W        = 7,
  parameter int ALLOW_JMP_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [MNEM_W-1:0] mnem,
  input  logic [2:0]        src_mode,
  input  logic [2:0]        src_reg,
  input  logic [2:0]        dst_mode,
  input  logic [2:0]        dst_reg,
  input  logic [7:0]        br_ofst,
  input  logic [15:0]       src_ext,
  input  logic [15:0]       dst_ext,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [15:0]       word,
  output logic              word_last,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_INSTR   = 2'd1,
    S_SRC_EXT = 2'd2,
    S_DST_EXT = 2'd3
  } state_t;

  // An operand carries an extension word for index/deferred-index modes and
  // for immediate/absolute (autoincrement through PC).
  function automatic logic need_ext(input logic [2:0] mode, input logic [2:0] rn);
    return (mode == 3'd6) || (mode == 3'd7) ||
           (((mode == 3'd2) || (mode == 3'd3)) && (rn == 3'd7));
  endfunction

  state_t      state_r, state_nxt_s;
  logic        req_ready_r, req_ready_nxt_s;
  logic        word_valid_r, word_valid_nxt_s;
  logic [15:0] word_r, word_nxt_s;
  logic        word_last_r, word_last_nxt_s;
  logic        err_r, err_nxt_s;
  logic [15:0] src_ext_r, src_ext_nxt_s;
  logic [15:0] dst_ext_r, dst_ext_nxt_s;
  logic        need_src_r, need_src_nxt_s;
  logic        need_dst_r, need_dst_nxt_s;

  logic [6:0]  m_s;
  logic [5:0]  sop_k_s;
  logic [5:0]  ss_s, dd_s;
  logic [15:0] instr_s;
  logic [15:0] br_base_s;
  logic        is_dop_s, has_dst_s, illegal_s;
  logic        need_src_s, need_dst_s;

  assign m_s     = mnem[6:0];
  assign sop_k_s = 6'(m_s - 7'd29);
  assign ss_s    = {src_mode, src_reg};
  assign dd_s    = {dst_mode, dst_reg};

  // Mnemonic decode: instruction word, operand classes and legality.
  always_comb begin
    instr_s   = 16'd0;
    br_base_s = 16'd0;
    is_dop_s  = 1'b0;
    has_dst_s = 1'b0;
    illegal_s = 1'b0;
    if (mnem > MNEM_W'(64)) begin
      illegal_s = 1'b1;
    end else if (m_s <= 7'd9) begin
      instr_s   = {m_s[0], 3'(m_s[3:1] + 3'd1), ss_s, dd_s};
      is_dop_s  = 1'b1;
      has_dst_s = 1'b1;
    end else if (m_s <= 7'd11) begin
      instr_s   = {m_s[0], 3'd6, ss_s, dd_s};
      is_dop_s  = 1'b1;
      has_dst_s = 1'b1;
    end else if (m_s <= 7'd26) begin
      case (m_s)
        7'd12:   br_base_s = 16'o000400;
        7'd13:   br_base_s = 16'o001000;
        7'd14:   br_base_s = 16'o001400;
        7'd15:   br_base_s = 16'o002000;
        7'd16:   br_base_s = 16'o002400;
        7'd17:   br_base_s = 16'o003000;
        7'd18:   br_base_s = 16'o003400;
        7'd19:   br_base_s = 16'o100000;
        7'd20:   br_base_s = 16'o100400;
        7'd21:   br_base_s = 16'o101000;
        7'd22:   br_base_s = 16'o101400;
        7'd23:   br_base_s = 16'o102000;
        7'd24:   br_base_s = 16'o102400;
        7'd25:   br_base_s = 16'o103000;
        7'd26:   br_base_s = 16'o103400;
        default: br_base_s = 16'd0;
      endcase
      instr_s = br_base_s | {8'd0, br_ofst};
    end else if (m_s == 7'd27) begin
      instr_s   = 16'o000100 | {10'd0, dd_s};
      has_dst_s = 1'b1;
      illegal_s = (dst_mode == 3'd0) && (ALLOW_JMP_REG == 0);
    end else if (m_s == 7'd28) begin
      instr_s   = 16'o004000 | {7'd0, src_reg, dd_s};
      has_dst_s = 1'b1;
      illegal_s = (dst_mode == 3'd0) && (ALLOW_JMP_REG == 0);
    end else if (m_s <= 7'd52) begin
      instr_s   = (16'o005000 + {5'd0, sop_k_s[5:1], 6'd0}) | {sop_k_s[0], 9'd0, dd_s};
      has_dst_s = 1'b1;
    end else begin
      case (m_s)
        7'd53: instr_s = 16'o000200 | {13'd0, dst_reg};
        7'd54: begin
          instr_s   = 16'o000300 | {10'd0, dd_s};
          has_dst_s = 1'b1;
        end
        7'd55:   instr_s = 16'o000000;
        7'd56:   instr_s = 16'o000240;
        7'd57:   instr_s = 16'o000241;
        7'd58:   instr_s = 16'o000242;
        7'd59:   instr_s = 16'o000244;
        7'd60:   instr_s = 16'o000250;
        7'd61:   instr_s = 16'o000261;
        7'd62:   instr_s = 16'o000262;
        7'd63:   instr_s = 16'o000264;
        7'd64:   instr_s = 16'o000270;
        default: instr_s = 16'd0;
      endcase
    end
  end

  assign need_src_s = is_dop_s && need_ext(src_mode, src_reg);
  assign need_dst_s = has_dst_s && need_ext(dst_mode, dst_reg);

  // Next-state and next-output logic; outputs are registered so they hold during stalls.
  always_comb begin
    state_nxt_s      = state_r;
    req_ready_nxt_s  = req_ready_r;
    word_valid_nxt_s = word_valid_r;
    word_nxt_s       = word_r;
    word_last_nxt_s  = word_last_r;
    err_nxt_s        = 1'b0;
    src_ext_nxt_s    = src_ext_r;
    dst_ext_nxt_s    = dst_ext_r;
    need_src_nxt_s   = need_src_r;
    need_dst_nxt_s   = need_dst_r;
    case (state_r)
      S_IDLE: begin
        if (req_valid && req_ready_r) begin
          if (illegal_s) begin
            err_nxt_s = 1'b1;
          end else begin
            state_nxt_s      = S_INSTR;
            req_ready_nxt_s  = 1'b0;
            word_valid_nxt_s = 1'b1;
            word_nxt_s       = instr_s;
            word_last_nxt_s  = !need_src_s && !need_dst_s;
            src_ext_nxt_s    = src_ext;
            dst_ext_nxt_s    = dst_ext;
            need_src_nxt_s   = need_src_s;
            need_dst_nxt_s   = need_dst_s;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_INSTR, S_SRC_EXT: begin
        if (word_valid_r && word_ready) begin
          if ((state_r == S_INSTR) && need_src_r) begin
            state_nxt_s     = S_SRC_EXT;
            word_nxt_s      = src_ext_r;
            word_last_nxt_s = !need_dst_r;
          end else if (need_dst_r) begin
            state_nxt_s     = S_DST_EXT;
            word_nxt_s      = dst_ext_r;
            word_last_nxt_s = 1'b1;
          end else begin
            state_nxt_s      = S_IDLE;
            req_ready_nxt_s  = 1'b1;
            word_valid_nxt_s = 1'b0;
            word_nxt_s       = 16'd0;
            word_last_nxt_s  = 1'b0;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      S_DST_EXT: begin
        if (word_valid_r && word_ready) begin
          state_nxt_s      = S_IDLE;
          req_ready_nxt_s  = 1'b1;
          word_valid_nxt_s = 1'b0;
          word_nxt_s       = 16'd0;
          word_last_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = S_DST_EXT;
        end
      end
      default: begin
        state_nxt_s      = S_IDLE;
        req_ready_nxt_s  = 1'b1;
        word_valid_nxt_s = 1'b0;
        word_nxt_s       = 16'd0;
        word_last_nxt_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any instruction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= S_IDLE;
      req_ready_r  <= 1'b1;
      word_valid_r <= 1'b0;
      word_r       <= 16'd0;
      word_last_r  <= 1'b0;
      err_r        <= 1'b0;
      src_ext_r    <= 16'd0;
      dst_ext_r    <= 16'd0;
      need_src_r   <= 1'b0;
      need_dst_r   <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      req_ready_r  <= req_ready_nxt_s;
      word_valid_r <= word_valid_nxt_s;
      word_r       <= word_nxt_s;
      word_last_r  <= word_last_nxt_s;
      err_r        <= err_nxt_s;
      src_ext_r    <= src_ext_nxt_s;
      dst_ext_r    <= dst_ext_nxt_s;
      need_src_r   <= need_src_nxt_s;
      need_dst_r   <= need_dst_nxt_s;
    end
  end

  assign req_ready  = req_ready_r;
  assign word_valid = word_valid_r;
  assign word       = word_r;
  assign word_last  = word_last_r;
  assign err        = err_r;

`ifdef PDP11_ENC_TRACE_EN
  logic [MNEM_W-1:0] trace_mnem_r;
  logic [1:0]        trace_idx_s;

  // Position of the word currently on the bus within its instruction.
  always_comb begin
    case (state_r)
      S_SRC_EXT: trace_idx_s = 2'd1;
      S_DST_EXT: trace_idx_s = need_src_r ? 2'd2 : 2'd1;
      default:   trace_idx_s = 2'd0;
    endcase
  end

  // Trace log of emitted words and rejected requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      trace_mnem_r <= '0;
    end else begin
      if (req_valid && req_ready_r) begin
        trace_mnem_r <= mnem;
      end else begin
        trace_mnem_r <= trace_mnem_r;
      end
      if (word_valid_r && word_ready) begin
        $display("ENC %0d w%0d %06o", trace_mnem_r, trace_idx_s, word_r);
      end
      if (err_r) begin
        $display("ENC ILLEGAL %0d", trace_mnem_r);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pdp11_instr_encoder.sv
// Directed scoreboard bench for pdp11_instr_encoder: expected words are queued
// when a request is issued and checked by a monitor as they are handed off.
module tb_pdp11_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  mnem;
  logic [2:0]  src_mode, src_reg, dst_mode, dst_reg;
  logic [7:0]  br_ofst;
  logic [15:0] src_ext, dst_ext;
  logic        word_valid;
  logic        word_ready;
  logic [15:0] word;
  logic        word_last;
  logic        err;

  int total = 0;
  int bad   = 0;
  logic [16:0] exp_q[$];

  pdp11_instr_encoder #(.MNEM_W(7), .ALLOW_JMP_REG(0)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .mnem(mnem), .src_mode(src_mode), .src_reg(src_reg), .dst_mode(dst_mode),
    .dst_reg(dst_reg), .br_ofst(br_ofst), .src_ext(src_ext), .dst_ext(dst_ext),
    .word_valid(word_valid), .word_ready(word_ready), .word(word),
    .word_last(word_last), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0o expected=%0o", tag, obs, expv);
    end
  endtask

  // Scoreboard monitor: every handshaken word must match the head of the queue.
  always @(negedge clk) begin
    logic [16:0] e;
    if (!reset && word_valid && word_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        assert (exp_q.size() != 0) else begin
          bad++;
          $error("FAIL extra_word observed=%06o expected=none", word);
        end
      end else begin
        e = exp_q.pop_front();
        chk("word", {16'd0, word}, {16'd0, e[15:0]});
        chk("word_last", {31'd0, word_last}, {31'd0, e[16]});
      end
    end
  end

  task automatic push(input logic [15:0] w, input logic last);
    exp_q.push_back({last, w});
  endtask

  // Present a request and hold it until accepted; returns just after the accepting edge.
  task automatic send(input logic [6:0] m, input logic [2:0] sm, input logic [2:0] sr,
                      input logic [2:0] dm, input logic [2:0] dr, input logic [7:0] of,
                      input logic [15:0] se, input logic [15:0] de);
    bit ok;
    ok = 1'b0;
    mnem = m; src_mode = sm; src_reg = sr; dst_mode = dm; dst_reg = dr;
    br_ofst = of; src_ext = se; dst_ext = de;
    req_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept_timeout", {31'd0, ok}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Wait (bounded) until every expected word has been consumed.
  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0) break;
    end
    chk("drain_q_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; word_ready = 1'b1;
    mnem = 7'd0; src_mode = 3'd0; src_reg = 3'd0; dst_mode = 3'd0; dst_reg = 3'd0;
    br_ofst = 8'd0; src_ext = 16'd0; dst_ext = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_word_valid", {31'd0, word_valid}, 32'd0);
    chk("rst_word", {16'd0, word}, 32'd0);
    chk("rst_word_last", {31'd0, word_last}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // MOV #1234,R3 with instruction word visible right after the accepting edge
    push(16'o012703, 1'b0); push(16'o001234, 1'b1);
    send(7'd0, 3'd2, 3'd7, 3'd0, 3'd3, 8'd0, 16'o001234, 16'd0);
    chk("mov_latency_valid", {31'd0, word_valid}, 32'd1);
    chk("mov_busy_ready", {31'd0, req_ready}, 32'd0);
    drain();

    // ADD 4(R1),10(R2), stall three cycles on the destination extension word
    word_ready = 1'b0;
    push(16'o066162, 1'b0); push(16'o000004, 1'b0); push(16'o000010, 1'b1);
    send(7'd10, 3'd6, 3'd1, 3'd6, 3'd2, 8'd0, 16'o000004, 16'o000010);
    word_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    word_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("add_stall_word", {16'd0, word}, 32'o000010);
      chk("add_stall_valid", {31'd0, word_valid}, 32'd1);
      chk("add_stall_last", {31'd0, word_last}, 32'd1);
      @(posedge clk); #1;
    end
    word_ready = 1'b1;
    drain();

    // BNE .-2 style offset and CLRB (R5)+, both single-word
    push(16'o001375, 1'b1);
    send(7'd13, 3'd0, 3'd0, 3'd0, 3'd0, 8'o375, 16'd0, 16'd0);
    drain();
    push(16'o105025, 1'b1);
    send(7'd30, 3'd0, 3'd0, 3'd2, 3'd5, 8'd0, 16'd0, 16'd0);
    drain();

    // SUB R0,@#2000: absolute destination carries only a dst extension word
    push(16'o160037, 1'b0); push(16'o002000, 1'b1);
    send(7'd11, 3'd0, 3'd0, 3'd3, 3'd7, 8'd0, 16'o777, 16'o002000);
    drain();

    // HALT encodes as all-zero word
    push(16'o000000, 1'b1);
    send(7'd55, 3'd0, 3'd0, 3'd0, 3'd0, 8'd0, 16'd0, 16'd0);
    drain();

    // Illegal mnemonic: one-cycle error pulse, no words
    send(7'd70, 3'd0, 3'd0, 3'd0, 3'd0, 8'd0, 16'd0, 16'd0);
    chk("ill_err_pulse", {31'd0, err}, 32'd1);
    chk("ill_no_word", {31'd0, word_valid}, 32'd0);
    @(posedge clk); #1;
    chk("ill_err_clear", {31'd0, err}, 32'd0);
    chk("ill_ready", {31'd0, req_ready}, 32'd1);
    chk("ill_no_word2", {31'd0, word_valid}, 32'd0);

    // JMP R2 is rejected
    send(7'd27, 3'd0, 3'd0, 3'd0, 3'd2, 8'd0, 16'd0, 16'd0);
    chk("jmp_reg_err", {31'd0, err}, 32'd1);
    chk("jmp_reg_no_word", {31'd0, word_valid}, 32'd0);
    @(posedge clk); #1;

    // Reset during ADD stall on the last word aborts the instruction
    word_ready = 1'b0;
    push(16'o066162, 1'b0); push(16'o000004, 1'b0); push(16'o000010, 1'b1);
    send(7'd10, 3'd6, 3'd1, 3'd6, 3'd2, 8'd0, 16'o000004, 16'o000010);
    word_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    word_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    chk("abort_valid", {31'd0, word_valid}, 32'd0);
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    word_ready = 1'b1;
    push(16'o000270, 1'b1);
    send(7'd64, 3'd0, 3'd0, 3'd0, 3'd0, 8'd0, 16'd0, 16'd0);
    drain();

    // Back-to-back MOV R1,R2 then RTS PC with one bubble between them
    push(16'o010102, 1'b1); push(16'o000207, 1'b1);
    send(7'd0, 3'd0, 3'd1, 3'd0, 3'd2, 8'd0, 16'd0, 16'd0);
    chk("b2b_first_valid", {31'd0, word_valid}, 32'd1);
    @(posedge clk); #1;
    chk("b2b_bubble_valid", {31'd0, word_valid}, 32'd0);
    chk("b2b_bubble_ready", {31'd0, req_ready}, 32'd1);
    send(7'd53, 3'd0, 3'd0, 3'd0, 3'd7, 8'd0, 16'd0, 16'd0);
    chk("b2b_second_valid", {31'd0, word_valid}, 32'd1);
    drain();

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
